// File: rtl/ahb_bus_grant_ctrl.sv
// Round-robin AHB grant controller with burst and lock hold.
// Optional ARB_HOLD_LIMIT_EN caps OPEN/LOCKED ownership at HOLD_LIMIT beats.
module ahb_bus_grant_ctrl #(
  parameter int MANAGERS    = 4,
  parameter int DEFAULT_MGR = 0,
  parameter int HOLD_LIMIT  = 16,
  localparam int IDW = (MANAGERS > 2) ? $clog2(MANAGERS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MANAGERS-1:0]   req,
  input  logic [MANAGERS-1:0]   lock,
  input  logic [2*MANAGERS-1:0] htrans,
  input  logic [3*MANAGERS-1:0] hburst,
  input  logic                  hready,
  output logic [MANAGERS-1:0]   grant,
  output logic [IDW-1:0]        addr_sel,
  output logic [IDW-1:0]        data_sel,
  output logic                  data_valid
);

  if (MANAGERS < 2 || DEFAULT_MGR >= MANAGERS || HOLD_LIMIT < 1)
  begin : g_bad_cfg
    $error("ahb_bus_grant_ctrl: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIXED,
    S_OPEN,
    S_LOCKED
  } state_t;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;

  localparam logic [IDW-1:0] DEF_ID = IDW'(DEFAULT_MGR);
  localparam logic [IDW-1:0] TOP_ID = IDW'(MANAGERS - 1);

  state_t          state;
  state_t          state_n;
  logic [3:0]      beats_left;
  logic [3:0]      beats_n;
  logic [IDW-1:0]  last_id;

  logic [1:0]      trans_a [MANAGERS];
  logic [2:0]      burst_a [MANAGERS];

  logic [1:0]      o_trans;
  logic [2:0]      o_burst;
  logic            o_lock;
  logic            o_req;
  logic            o_active;
  logic            accepted;
  logic [3:0]      len_m1;

  logic            start;
  logic            burst_end;
  logic            force_rearb;
  logic            rearb;
  logic            found;
  logic [IDW-1:0]  nxt_id;

  for (genvar i = 0; i < MANAGERS; i++) begin : g_unpack
    assign trans_a[i] = htrans[2*i +: 2];
    assign burst_a[i] = hburst[3*i +: 3];
  end

  assign o_trans  = trans_a[addr_sel];
  assign o_burst  = burst_a[addr_sel];
  assign o_lock   = lock[addr_sel];
  assign o_req    = req[addr_sel];
  assign o_active = (o_trans == T_NSEQ) || (o_trans == T_SEQ);
  assign accepted = hready && o_active;

  always_comb begin
    len_m1 = 4'd0;
    unique case (1'b1)
      o_burst[2:1] == 2'b01: len_m1 = 4'd3;
      o_burst[2:1] == 2'b10: len_m1 = 4'd7;
      o_burst[2:1] == 2'b11: len_m1 = 4'd15;
      default:               len_m1 = 4'd0;
    endcase
  end

  // Round robin: lowest requester above last_id, else lowest overall.
  always_comb begin
    found  = 1'b0;
    nxt_id = DEF_ID;
    for (int i = 0; i < MANAGERS; i++) begin
      if (!found && req[i] && (IDW'(i) > last_id)) begin
        found  = 1'b1;
        nxt_id = IDW'(i);
      end
    end
    for (int i = 0; i < MANAGERS; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        nxt_id = IDW'(i);
      end
    end
  end

  always_comb begin
    state_n   = state;
    beats_n   = beats_left;
    start     = 1'b0;
    burst_end = 1'b0;
    if (accepted && o_trans == T_NSEQ) begin
      start = 1'b1;
      if (o_lock) begin
        state_n = S_LOCKED;
      end else if (o_burst == 3'd1) begin
        state_n = S_OPEN;
      end else if (o_burst == 3'd0) begin
        burst_end = 1'b1;
      end else begin
        state_n = S_FIXED;
        beats_n = len_m1;
      end
    end else begin
      unique case (state)
        S_FIXED: begin
          if (accepted) begin
            if (beats_left == 4'd1) burst_end = 1'b1;
            else beats_n = beats_left - 4'd1;
          end
        end
        S_OPEN: begin
          if (o_trans == T_IDLE ||
              (!o_req && o_trans != T_BUSY))
            burst_end = 1'b1;
        end
        S_LOCKED: begin
          if (o_trans == T_IDLE && !o_lock)
            burst_end = 1'b1;
        end
        default: ;
      endcase
    end
    rearb = hready && (burst_end || force_rearb ||
                       (state == S_IDLE && !start));
    if (rearb) state_n = S_IDLE;
    if (!hready) begin
      state_n = state;
      beats_n = beats_left;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HCW = $clog2(HOLD_LIMIT + 1);

  logic [HCW-1:0] hold_cnt;
  logic [HCW-1:0] hold_n;
  logic           in_hold;
  logic           others_req;

  assign in_hold    = (state == S_OPEN) || (state == S_LOCKED);
  assign others_req = |(req & ~grant);
  assign force_rearb = in_hold && others_req &&
                       (int'(hold_cnt) >= HOLD_LIMIT);

  always_comb begin
    hold_n = hold_cnt;
    if (hready) begin
      if (rearb)
        hold_n = '0;
      else if (start)
        hold_n = HCW'(1);
      else if (accepted && in_hold &&
               int'(hold_cnt) < HOLD_LIMIT)
        hold_n = hold_cnt + HCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hold_cnt <= '0;
    else       hold_cnt <= hold_n;
  end
`else
  assign force_rearb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      beats_left <= 4'd0;
      last_id    <= TOP_ID;
      grant      <= MANAGERS'(1) << DEFAULT_MGR;
      addr_sel   <= DEF_ID;
      data_sel   <= DEF_ID;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      beats_left <= beats_n;
      if (hready) begin
        data_sel   <= addr_sel;
        data_valid <= o_active;
        if (rearb) begin
          addr_sel <= nxt_id;
          grant    <= MANAGERS'(1) << nxt_id;
          if (found) last_id <= nxt_id;
        end
      end
    end
  end

endmodule

// File: doc/ahb_bus_grant_ctrl.md
Name: ahb_bus_grant_ctrl

Overview:
- Shares the single AHB address/data path between MANAGERS requesting managers.
- Decides who owns the address phase and tracks who owns the data phase, one cycle behind.
- Uses round-robin priority and holds the grant for a whole burst or locked sequence.
- Drives the address-mux and data-mux selects for the multi-manager interconnect.

Parameters:
MANAGERS, 4, number of managers; must be 2 or more. IDW = max(1, clog2(MANAGERS)).
DEFAULT_MGR, 0, manager that is parked on the bus when nobody requests.
HOLD_LIMIT, 16, beat cap for undefined-length ownership; used only with ARB_HOLD_LIMIT_EN.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  MANAGERS  bus request per manager (bit i = manager i)
lock  input  MANAGERS  HMASTLOCK per manager
htrans  input  2*MANAGERS  HTRANS per manager, slice [2i+1:2i]
hburst  input  3*MANAGERS  HBURST per manager, slice [3i+2:3i]
hready  input  1  shared HREADY from the selected subordinate
grant  output  MANAGERS  one-hot address-phase grant, registered
addr_sel  output  IDW  index of the address-phase owner (matches grant)
data_sel  output  IDW  index of the data-phase owner
data_valid  output  1  data phase holds an active (NONSEQ/SEQ) transfer

Behaviour:
- Encodings: HTRANS 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ. HBURST 0 SINGLE, 1 INCR, 2/3 WRAP4/INCR4, 4/5 WRAP8/INCR8, 6/7 WRAP16/INCR16.
- Reset values: grant = one-hot DEFAULT_MGR; addr_sel = data_sel = DEFAULT_MGR; data_valid = 0; last_id = MANAGERS-1, so manager 0 has top priority; beat counter = 0; state = IDLE.
- "Owner" is the manager addressed by addr_sel. "Accepted beat" means a cycle with hready=1 and owner htrans equal to NONSEQ or SEQ.
- States:
  - IDLE: bus is parked; no burst in progress.
  - FIXED: owner is in a fixed-length burst; beats_left holds the remaining count.
  - OPEN: owner is in an undefined-length INCR burst.
  - LOCKED: owner's lock bit is high.
- Transitions, evaluated only on cycles with hready=1:
  - Accepted NONSEQ:
    - If lock is high, go to LOCKED.
    - Otherwise, if hburst is 1 (INCR), go to OPEN.
    - Otherwise, if hburst is 0 (SINGLE), the burst ends this beat.
    - Otherwise, load beats_left = length-1 and go to FIXED.
  - Accepted SEQ in FIXED: decrement beats_left. The burst ends when a SEQ is accepted with beats_left = 1.
  - OPEN ends when the owner drives IDLE, or when req[owner] is 0 at a non-BUSY cycle.
  - LOCKED ends when the owner drives IDLE with lock low.
  - BUSY never counts as a beat and never ends a burst.
- Rearbitration point: hready=1 and either state is IDLE or the burst ends this cycle.
  - At this point, next owner = first i with req[i]=1, searching cyclically from last_id+1.
  - If no req is set, next owner = DEFAULT_MGR.
  - On the next edge, grant and addr_sel update and last_id takes the new owner only if it requested. State goes to IDLE unless the new owner's NONSEQ is accepted.
- grant is never changed while hready=0; a stalled transfer keeps its owner.
- Data phase: on every hready=1 edge, data_sel <= addr_sel and data_valid <= (owner htrans is NONSEQ or SEQ). Both hold while hready=0.
- Simultaneous events: a burst ending with new requests arriving in the same cycle is treated as a rearbitration point with the new requests visible. A requester dropping req mid-burst does not cut a FIXED burst.
- Reset asserted mid-burst: every register returns to its reset value on the next edge, regardless of hready.

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined: OPEN and LOCKED states count accepted beats. When the count reaches HOLD_LIMIT and some other manager's req is high, the next hready=1 cycle is forced to be a rearbitration point. A lock in progress is broken, with the priority and grant change applied as normal.
- Undefined: no beat counting in OPEN or LOCKED; the owner keeps the bus indefinitely.

Test Plan:
- Reset, req=0000: grant=0001, addr_sel=0, data_sel=0, data_valid=0. Hold for 5 cycles; values stay unchanged.
- req=1111, every manager issues SINGLE NONSEQ with hready=1: grant sequence is 0001, 0010, 0100, 1000, 0001 on consecutive rearbitration points.
- Manager 1 issues INCR4 while req=1010 and hready toggles 1,0,1,1,0,1,1: grant stays 0010 until the 4th accepted beat. Then grant=1000, and data_sel=1 for one more hready=1 cycle.
- Manager 2 is locked with INCR while req=0101: grant stays 0100 for 40 beats. Without ARB_HOLD_LIMIT_EN it then ends on IDLE with lock=0. With the macro and HOLD_LIMIT=16, grant moves to 0001 after beat 16.
- Reset asserted in the middle of a WRAP8 burst: next cycle shows grant=0001, state IDLE, data_valid=0.
- Owner inserts BUSY during INCR8: beats_left is unchanged during BUSY and the burst ends only after 8 accepted beats.
